cdc_2phase_arbiter: RTL and testbench

CDC_2PHASE_ARBITER -- requirements
Module: cdc_2phase_arbiter

---
 rtl/cdc_2phase_arbiter.sv | 132 +++++++++++++
 tb/tb_cdc_2phase_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_2phase_arbiter.sv
// Round-robin arbiter feeding one two-phase CDC channel from NumIn requesters.
// Per-requester credit counters are built only with CDC_2PHASE_ARBITER_CREDIT_EN.
module cdc_2phase_arbiter #(
    parameter int NumIn       = 4,
    parameter int DataWidth   = 32,
    parameter int CreditDepth = 4,
    localparam int IdWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumIn-1:0]           in_valid_i,
    input  logic [NumIn*DataWidth-1:0] in_data_i,
    output logic [NumIn-1:0]           in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DataWidth-1:0]       out_data_o,
    output logic [IdWidth-1:0]         out_id_o,
    input  logic                       credit_valid_i,
    input  logic [IdWidth-1:0]         credit_id_i,
    output logic                       credit_err_o
);
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic                 state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [IdWidth-1:0]   rr_q, rr_d;
    logic [NumIn-1:0]     elig;
    logic                 found, grant;
    logic [IdWidth-1:0]   winner;

`ifdef CDC_2PHASE_ARBITER_CREDIT_EN
    localparam int CntW = $clog2(CreditDepth + 1);
    logic [NumIn-1:0][CntW-1:0] credit_q, credit_d;
    logic                       err_q, err_d;

    always_comb begin
        for (int i = 0; i < NumIn; i++) elig[i] = in_valid_i[i] && (credit_q[i] != '0);
    end

    // A return is checked against the current count; a grant in the same
    // cycle does not make room for it.
    always_comb begin
        logic ret, take, ovf;
        credit_d = credit_q;
        ovf      = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            ret  = credit_valid_i && (credit_id_i == IdWidth'(i));
            if (ret && (credit_q[i] == CntW'(CreditDepth))) begin
                ovf = 1'b1;
                ret = 1'b0;
            end
            take = grant && (winner == IdWidth'(i));
            if (ret && !take)      credit_d[i] = credit_q[i] + CntW'(1);
            else if (take && !ret) credit_d[i] = credit_q[i] - CntW'(1);
        end
        err_d = err_q | ovf | (credit_valid_i && (int'(credit_id_i) >= NumIn));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= {NumIn{CntW'(CreditDepth)}};
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign credit_err_o = err_q;
`else
    logic unused_credit;
    assign unused_credit = ^{credit_valid_i, credit_id_i};
    assign elig          = in_valid_i;
    assign credit_err_o  = 1'b0;
`endif

    // First eligible requester at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NumIn; k++) begin
            idx = (int'(rr_q) + k) % NumIn;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = IdWidth'(idx);
            end
        end
    end

    assign grant = found && ((state_q == EMPTY) || out_ready_i);

    always_comb begin
        for (int i = 0; i < NumIn; i++) in_ready_o[i] = rst_ni && grant && (winner == IdWidth'(i));
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        rr_d    = rr_q;
        if (grant) begin
            state_d = FULL;
            data_d  = in_data_i[int'(winner)*DataWidth +: DataWidth];
            id_d    = winner;
            rr_d    = IdWidth'((int'(winner) + 1) % NumIn);
        end else if ((state_q == FULL) && out_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    assign out_valid_o = (state_q == FULL);
    assign out_data_o  = data_q;
    assign out_id_o    = id_q;
endmodule

// File: tb/tb_cdc_2phase_arbiter.sv
// Directed bench for cdc_2phase_arbiter (NumIn=4, CreditDepth=2); expectations
// adapt to whether CDC_2PHASE_ARBITER_CREDIT_EN is defined.
module tb_cdc_2phase_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int D = 2;
`ifdef CDC_2PHASE_ARBITER_CREDIT_EN
    localparam bit CR = 1'b1;
`else
    localparam bit CR = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [N-1:0]   in_valid_i = '0;
    logic [N*W-1:0] in_data_i = '0;
    logic [N-1:0]   in_ready_o;
    logic           out_valid_o;
    logic           out_ready_i = 1'b0;
    logic [W-1:0]   out_data_o;
    logic [1:0]     out_id_o;
    logic           credit_valid_i = 1'b0;
    logic [1:0]     credit_id_i = '0;
    logic           credit_err_o;

    int total = 0;
    int bad   = 0;

    cdc_2phase_arbiter #(.NumIn(N), .DataWidth(W), .CreditDepth(D)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_id_o(out_id_o),
        .credit_valid_i(credit_valid_i), .credit_id_i(credit_id_i),
        .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_data_i[i*W +: W] = 32'h10 + i;

        // Reset state, with valid requests held high during reset
        in_valid_i = 4'hF;
        out_ready_i = 1'b1;
        tick();
        #1;
        chk("rst_ready", 32'(in_ready_o), 0);
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_id", 32'(out_id_o), 0);
        chk("rst_err", 32'(credit_err_o), 0);
        rst_ni = 1'b1;

        // Back-to-back round robin 0,1,2,3,0
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_ready%0d", k), 32'(in_ready_o), 32'(1 << (k % 4)));
            tick();
            chk($sformatf("rr_valid%0d", k), 32'(out_valid_o), 1);
            chk($sformatf("rr_id%0d", k), 32'(out_id_o), 32'(k % 4));
            chk($sformatf("rr_data%0d", k), out_data_o, 32'h10 + 32'(k % 4));
        end

        // Backpressure hold with id 2
        do_reset();
        in_valid_i = 4'b0100;
        out_ready_i = 1'b0;
        in_data_i[2*W +: W] = 32'hA5A5A5A5;
        #1;
        chk("bp_grant", 32'(in_ready_o), 32'b0100);
        tick();
        in_data_i[2*W +: W] = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_ready%0d", k), 32'(in_ready_o), 0);
            chk($sformatf("bp_id%0d", k), 32'(out_id_o), 2);
            chk($sformatf("bp_data%0d", k), out_data_o, 32'hA5A5A5A5);
            chk($sformatf("bp_valid%0d", k), 32'(out_valid_o), 1);
            tick();
        end
        in_valid_i = '0;
        out_ready_i = 1'b1;
        tick();
        chk("bp_drain", 32'(out_valid_o), 0);

        // Credit exhaustion on requester 1, then one return
        do_reset();
        in_valid_i = 4'b0010;
        #1;
        chk("cr_g1", 32'(in_ready_o), 32'b0010);
        tick();
        chk("cr_g2", 32'(in_ready_o), 32'b0010);
        tick();
        chk("cr_stall", 32'(in_ready_o), CR ? 32'b0000 : 32'b0010);
        tick();
        chk("cr_empty", 32'(out_valid_o), CR ? 0 : 1);
        credit_valid_i = 1'b1;
        credit_id_i = 2'd1;
        tick();
        credit_valid_i = 1'b0;
        #1;
        chk("cr_ret_grant", 32'(in_ready_o), 32'b0010);
        tick();
        chk("cr_ret_stall", 32'(in_ready_o), CR ? 32'b0000 : 32'b0010);
        chk("cr_ret_err", 32'(credit_err_o), 0);

        // Simultaneous grant and return on id 3 with credit 1
        do_reset();
        in_valid_i = 4'b1000;
        tick();
        credit_valid_i = 1'b1;
        credit_id_i = 2'd3;
        #1;
        chk("sim_grant", 32'(in_ready_o), 32'b1000);
        tick();
        credit_valid_i = 1'b0;
        #1;
        chk("sim_left1", 32'(in_ready_o), 32'b1000);
        tick();
        chk("sim_left0", 32'(in_ready_o), CR ? 32'b0000 : 32'b1000);
        chk("sim_err", 32'(credit_err_o), 0);

        // Overflow return on id 0 while full of credit
        do_reset();
        in_valid_i = '0;
        credit_valid_i = 1'b1;
        credit_id_i = 2'd0;
        tick();
        credit_valid_i = 1'b0;
        chk("ovf_err", 32'(credit_err_o), 32'(CR));
        tick();
        tick();
        chk("ovf_sticky", 32'(credit_err_o), 32'(CR));
        in_valid_i = 4'b0001;
        tick();
        tick();
        chk("ovf_unchanged", 32'(in_ready_o), CR ? 32'b0000 : 32'b0001);
        chk("ovf_sticky2", 32'(credit_err_o), 32'(CR));

        // Asynchronous reset while FULL
        do_reset();
        in_valid_i = 4'b1000;
        tick();
        chk("ar_full", 32'(out_valid_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid_o), 0);
        chk("ar_ready", 32'(in_ready_o), 0);
        chk("ar_err", 32'(credit_err_o), 0);
        tick();
        rst_ni = 1'b1;
        in_valid_i = 4'b1010;
        #1;
        chk("ar_first", 32'(in_ready_o), 32'b0010);
        tick();
        in_valid_i = 4'b1000;
        #1;
        chk("ar_c1", 32'(in_ready_o), 32'b1000);
        tick();
        chk("ar_c2", 32'(in_ready_o), 32'b1000);
        tick();
        chk("ar_c3", 32'(in_ready_o), CR ? 32'b0000 : 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
